// File: rtl/intersection_phase_scheduler.sv
// rtl/intersection_phase_scheduler.sv - two-approach intersection phase sequencer with left/ped service and preemption
module intersection_phase_scheduler #(
    parameter int unsigned FORWARD_T = 15,
    parameter int unsigned RIGHT_T   = 10,
    parameter int unsigned LEFT_T    = 10,
    parameter int unsigned YELLOW_T  = 3,
    parameter int unsigned ALLRED_T  = 2,
    parameter int unsigned PED_T     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        switch,
    input  logic        emergency,
    input  logic        left_req_a,
    input  logic        left_req_b,
    input  logic        ped_req,
    output logic [1:0]  out_a,
    output logic        yellow_a,
    output logic [1:0]  out_b,
    output logic        yellow_b,
    output logic        ped_walk,
    output logic        turn,
    output logic [2:0]  phase,
    output logic [31:0] counter
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ALLRED = 3'd1;
    localparam logic [2:0] S_FWD    = 3'd2;
    localparam logic [2:0] S_RIGHT  = 3'd3;
    localparam logic [2:0] S_LEFT   = 3'd4;
    localparam logic [2:0] S_YEL    = 3'd5;
    localparam logic [2:0] S_PED    = 3'd6;
    localparam logic [2:0] S_EMERG  = 3'd7;

    localparam logic [1:0] L_OFF   = 2'b00;
    localparam logic [1:0] L_LEFT  = 2'b01;
    localparam logic [1:0] L_FWD   = 2'b10;
    localparam logic [1:0] L_RIGHT = 2'b11;

    logic [2:0]  phase_q, phase_d;
    logic [31:0] counter_q, counter_d;
    logic        turn_q, turn_d;
    logic        left_pend_a_q, left_pend_a_d;
    logic        left_pend_b_q, left_pend_b_d;
    logic        ped_pend_q, ped_pend_d;
    logic        clr_left_a, clr_left_b, clr_ped;
    logic        left_pend_turn;
    logic        expire;

    assign left_pend_turn = turn_q ? left_pend_b_q : left_pend_a_q;
    assign expire         = tick && (counter_q <= 32'd1);

    always_comb begin
        phase_d    = phase_q;
        counter_d  = counter_q;
        turn_d     = turn_q;
        clr_left_a = 1'b0;
        clr_left_b = 1'b0;
        clr_ped    = 1'b0;

        if (switch) begin
            phase_d   = S_IDLE;
            counter_d = 32'd0;
        end else if (emergency && (phase_q == S_FWD || phase_q == S_RIGHT || phase_q == S_LEFT)) begin
            phase_d   = S_YEL;
            counter_d = YELLOW_T;
        end else if (emergency && (phase_q == S_ALLRED || phase_q == S_PED)) begin
            phase_d   = S_EMERG;
            counter_d = 32'd0;
        end else if (phase_q == S_IDLE || (phase_q == S_EMERG && !emergency)) begin
            phase_d   = S_ALLRED;
            counter_d = ALLRED_T;
        end else if (phase_q != S_EMERG && tick && !expire) begin
            counter_d = counter_q - 32'd1;
        end else if (phase_q != S_EMERG && expire) begin
            case (phase_q)
                S_ALLRED: begin
                    if (ped_pend_q) begin
                        phase_d   = S_PED;
                        counter_d = PED_T;
                        clr_ped   = 1'b1;
                    end else begin
                        phase_d   = S_FWD;
                        counter_d = FORWARD_T;
                    end
                end
                S_PED: begin
                    phase_d   = S_FWD;
                    counter_d = FORWARD_T;
                end
                S_FWD: begin
                    phase_d   = S_RIGHT;
                    counter_d = RIGHT_T;
                end
                S_RIGHT: begin
                    if (left_pend_turn) begin
                        phase_d    = S_LEFT;
                        counter_d  = LEFT_T;
                        clr_left_a = !turn_q;
                        clr_left_b = turn_q;
                    end else begin
                        phase_d   = S_YEL;
                        counter_d = YELLOW_T;
                    end
                end
                S_LEFT: begin
                    phase_d   = S_YEL;
                    counter_d = YELLOW_T;
                end
                S_YEL: begin
                    turn_d = !turn_q;
                    if (emergency) begin
                        phase_d   = S_EMERG;
                        counter_d = 32'd0;
                    end else begin
                        phase_d   = S_ALLRED;
                        counter_d = ALLRED_T;
                    end
                end
                default: begin
                    phase_d   = phase_q;
                    counter_d = counter_q;
                end
            endcase
        end

        // A request arriving in the serving cycle survives the clear.
        left_pend_a_d = (left_pend_a_q && !clr_left_a) || left_req_a;
        left_pend_b_d = (left_pend_b_q && !clr_left_b) || left_req_b;
        ped_pend_d    = (ped_pend_q && !clr_ped) || ped_req;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q       <= S_IDLE;
            counter_q     <= 32'd0;
            turn_q        <= 1'b0;
            left_pend_a_q <= 1'b0;
            left_pend_b_q <= 1'b0;
            ped_pend_q    <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            counter_q     <= counter_d;
            turn_q        <= turn_d;
            left_pend_a_q <= left_pend_a_d;
            left_pend_b_q <= left_pend_b_d;
            ped_pend_q    <= ped_pend_d;
        end
    end

    logic [1:0] own_light;
    logic       own_yellow;

    always_comb begin
        own_light  = L_OFF;
        own_yellow = 1'b0;
        ped_walk   = 1'b0;
        case (phase_q)
            S_FWD:   own_light  = L_FWD;
            S_RIGHT: own_light  = L_RIGHT;
            S_LEFT:  own_light  = L_LEFT;
            S_YEL:   own_yellow = 1'b1;
            S_PED:   ped_walk   = 1'b1;
            default: own_light  = L_OFF;
        endcase
        out_a    = turn_q ? L_OFF : own_light;
        yellow_a = !turn_q && own_yellow;
        out_b    = turn_q ? own_light : L_OFF;
        yellow_b = turn_q && own_yellow;
    end

    assign turn    = turn_q;
    assign phase   = phase_q;
    assign counter = counter_q;

endmodule
